sponge_ctrl: RTL

SPONGE_CTRL -- requirements
Module: sponge_ctrl

---
 rtl/sponge_pkg.sv | 18 +
 rtl/lane_counter.sv | 27 ++
 rtl/sponge_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sponge_pkg.sv
// Shared definitions for the sponge absorb/permute/squeeze controller.
package sponge_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StClear     = 3'd1,
    StAbsorb    = 3'd2,
    StPermStart = 3'd3,
    StPermWait  = 3'd4,
    StSqueeze   = 3'd5
  } state_e;

  localparam int unsigned NumLanes      = 25;
  localparam int unsigned DefRateLanes  = 17;
  localparam int unsigned DefOutLanes   = 4;
  localparam int unsigned DefTimeout    = 255;

endpackage

// File: rtl/lane_counter.sv
// 5-bit lane counter with clear, saturating increment and terminal compare.
module lane_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [4:0] term,
  output logic [4:0] cnt,
  output logic       at_term
);

  logic [4:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 5'd0;
    end else if (clr) begin
      cnt_q <= 5'd0;
    end else if (inc && cnt_q != 5'd31) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

  assign cnt     = cnt_q;
  assign at_term = (cnt_q == term);

endmodule

// File: rtl/sponge_ctrl.sv
// Sponge hash controller: clears state, absorbs rate lanes, runs the round
// engine per block and squeezes the output lanes.
module sponge_ctrl
  import sponge_pkg::*;
#(
  parameter int unsigned RATE_LANES = DefRateLanes,
  parameter int unsigned OUT_LANES  = DefOutLanes,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [4:0] st_addr,
  output logic       st_clr_en,
  output logic       st_xor_en,
  output logic       core_start,
  input  logic       core_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic             last_blk_q;
  logic [WdW-1:0]   wd_q;
  logic             err_q;
  logic             done_q;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [4:0]       cnt_term;
  logic [4:0]       cnt;
  logic             cnt_at_term;

  // One counter serves clear, absorb and squeeze; the phases never overlap.
  lane_counter u_lane_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .cnt     (cnt),
    .at_term (cnt_at_term)
  );

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_term = 5'd0;
    unique case (state_q)
      StClear: begin
        cnt_term = 5'(NumLanes - 1);
        cnt_clr  = cnt_at_term;
        cnt_inc  = !cnt_at_term;
      end
      StAbsorb: begin
        cnt_term = 5'(RATE_LANES - 1);
        if (in_valid) begin
          cnt_clr = cnt_at_term || in_last;
          cnt_inc = !(cnt_at_term || in_last);
        end
      end
      StSqueeze: begin
        cnt_term = 5'(OUT_LANES - 1);
        if (out_ready) begin
          cnt_clr = cnt_at_term;
          cnt_inc = !cnt_at_term;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_blk_q <= 1'b0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StClear;
            err_q   <= 1'b0;
          end
        end
        StClear: begin
          if (cnt_at_term) state_q <= StAbsorb;
        end
        StAbsorb: begin
          if (in_valid) begin
            if (cnt_at_term) begin
              last_blk_q <= in_last;
              state_q    <= StPermStart;
            end else if (in_last) begin
              // Short final block: the lane is still written, but the hash aborts.
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StPermStart: begin
          wd_q    <= '0;
          state_q <= StPermWait;
        end
        StPermWait: begin
          if (core_done) begin
            state_q <= last_blk_q ? StSqueeze : StAbsorb;
          end else begin
            if (wd_q != '1) wd_q <= wd_q + WdW'(1);
            if (wd_q == WdW'(TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StSqueeze: begin
          if (out_ready && cnt_at_term) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    in_ready   = (state_q == StAbsorb);
    st_clr_en  = (state_q == StClear);
    st_xor_en  = (state_q == StAbsorb) && in_valid;
    core_start = (state_q == StPermStart);
    out_valid  = (state_q == StSqueeze);
    out_last   = (state_q == StSqueeze) && cnt_at_term;
    st_addr    = 5'd0;
    if (state_q == StClear || state_q == StAbsorb || state_q == StSqueeze) st_addr = cnt;
    done       = done_q;
    err        = err_q;
  end

endmodule
